// File: rtl/req_arbiter.sv
// Single-resource req/gnt/done arbiter with hold-time watchdog and one dead cycle after each release.
// Fixed highest-index priority by default; define ARB_ROUND_ROBIN_EN for rotating priority.
module req_arbiter #(
  parameter int NREQ     = 4,
  parameter int IDW      = 2,
  parameter int MAX_HOLD = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            done,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id,
  output logic            gnt_valid,
  output logic            timeout
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t          state, state_nxt;
  logic [7:0]      hold_cnt, hold_nxt;
  logic [IDW-1:0]  last_id, last_nxt;
  logic [NREQ-1:0] gnt_nxt;
  logic [IDW-1:0]  id_nxt;
  logic            vld_nxt;
  logic            to_nxt;
  logic [IDW-1:0]  winner;

`ifdef ARB_ROUND_ROBIN_EN
  int rr_best;
  int rr_dist;

  // Distance of each requester from the slot after the previous winner; nearest set bit wins.
  always_comb begin
    winner  = '0;
    rr_best = NREQ;
    rr_dist = 0;
    for (int i = 0; i < NREQ; i++) begin
      rr_dist = (i + NREQ - 1 - int'(last_id)) % NREQ;
      if (req[i] && (rr_dist < rr_best)) begin
        rr_best = rr_dist;
        winner  = IDW'(i);
      end
    end
  end
`else
  always_comb begin
    winner = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req[i]) winner = IDW'(i);
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      last_id   <= IDW'(NREQ - 1);
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nxt;
      hold_cnt  <= hold_nxt;
      last_id   <= last_nxt;
      gnt       <= gnt_nxt;
      gnt_id    <= id_nxt;
      gnt_valid <= vld_nxt;
      timeout   <= to_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    last_nxt  = last_id;
    gnt_nxt   = '0;
    id_nxt    = '0;
    vld_nxt   = 1'b0;
    to_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          state_nxt = GRANT;
          hold_nxt  = '0;
          last_nxt  = winner;
          gnt_nxt   = {{(NREQ-1){1'b0}}, 1'b1} << winner;
          id_nxt    = winner;
          vld_nxt   = 1'b1;
        end
      end
      GRANT: begin
        // done outranks both abandon and watchdog expiry
        if (done || !(|(req & gnt))) begin
          state_nxt = GAP;
        end else if (hold_cnt == 8'(MAX_HOLD - 1)) begin
          state_nxt = GAP;
          to_nxt    = 1'b1;
        end else begin
          hold_nxt = (hold_cnt == 8'hFF) ? hold_cnt : hold_cnt + 8'd1;
          gnt_nxt  = gnt;
          id_nxt   = gnt_id;
          vld_nxt  = 1'b1;
        end
      end
      GAP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_req_arbiter.sv
// Bench for req_arbiter: vector table, hand-written corner sequences, randomized run against a model.
module tb_req_arbiter;
  localparam int NREQ     = 4;
  localparam int IDW      = 2;
  localparam int MAX_HOLD = 15;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [NREQ-1:0] req;
  logic            done;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_id;
  logic            gnt_valid;
  logic            timeout;

  int checks = 0;
  int errors = 0;

  req_arbiter #(.NREQ(NREQ), .IDW(IDW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt(gnt), .gnt_id(gnt_id), .gnt_valid(gnt_valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] id;
    logic       vld;
    logic       to;
  } vec_t;

  vec_t tbl[14];

  // Reference model: who owns the resource, for how many cycles, and how many dead cycles remain.
  int   m_owner;
  int   m_age;
  int   m_cool;
  int   m_last;
  logic m_to;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] r, input logic d, input logic [3:0] g,
                              input logic [1:0] id, input logic v, input logic t);
    vec_t x;
    x.req = r; x.done = d; x.gnt = g; x.id = id; x.vld = v; x.to = t;
    return x;
  endfunction

  function automatic int pick(input logic [3:0] r, input int last);
    if (RR) begin
      for (int k = 1; k <= NREQ; k++) begin
        if (((r >> ((last + k) % NREQ)) & 4'd1) != 4'd0) return (last + k) % NREQ;
      end
    end else begin
      for (int i = NREQ - 1; i >= 0; i--) begin
        if (((r >> i) & 4'd1) != 4'd0) return i;
      end
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_age = 0; m_cool = 0; m_last = NREQ - 1; m_to = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic d);
    int w;
    m_to = 1'b0;
    if (m_owner >= 0) begin
      if (d || (((r >> m_owner) & 4'd1) == 4'd0)) begin
        m_owner = -1; m_cool = 1;
      end else if (m_age == MAX_HOLD) begin
        m_owner = -1; m_cool = 1; m_to = 1'b1;
      end else begin
        m_age++;
      end
    end else if (m_cool > 0) begin
      m_cool--;
    end else begin
      w = pick(r, m_last);
      if (w >= 0) begin
        m_owner = w; m_age = 1; m_last = w;
      end
    end
  endtask

  task automatic cycle();
    model_step(req, done);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req = '0; done = 1'b0; rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit");
    $fatal(1, "bench time limit");
  end

  initial begin
    int n, nto;
    int exp_seq[5];
    logic [3:0] eg;
    logic found;

    rst = 1'b1; req = '0; done = 1'b0;

    tbl[0]  = mk(4'b1011, 1'b0, RR ? 4'b0001 : 4'b1000, RR ? 2'd0 : 2'd3, 1'b1, 1'b0);
    tbl[1]  = mk(4'b0011, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
    tbl[2]  = mk(4'b0011, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
    tbl[3]  = mk(4'b0011, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
    tbl[4]  = mk(4'b1001, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
    tbl[5]  = mk(4'b1000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
    tbl[6]  = mk(4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0);
    tbl[7]  = mk(4'b1100, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0);
    tbl[8]  = mk(4'b0100, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
    tbl[9]  = mk(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
    tbl[10] = mk(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
    tbl[11] = mk(4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
    tbl[12] = mk(4'b0110, 1'b0, RR ? 4'b0010 : 4'b0100, RR ? 2'd1 : 2'd2, 1'b1, 1'b0);
    tbl[13] = mk(4'b0110, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);

    do_reset();
    chk("reset_gnt", 32'(gnt), 32'd0);
    chk("reset_gnt_id", 32'(gnt_id), 32'd0);
    chk("reset_gnt_valid", 32'(gnt_valid), 32'd0);
    chk("reset_timeout", 32'(timeout), 32'd0);

    for (int i = 0; i < 14; i++) begin
      req = tbl[i].req; done = tbl[i].done;
      cycle();
      chk($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
      chk($sformatf("vec%0d_valid", i), 32'(gnt_valid), 32'(tbl[i].vld));
      chk($sformatf("vec%0d_timeout", i), 32'(timeout), 32'(tbl[i].to));
      if (tbl[i].vld) chk($sformatf("vec%0d_gnt_id", i), 32'(gnt_id), 32'(tbl[i].id));
    end
    done = 1'b0;

    // Reset asserted mid-grant clears outputs without a clock edge
    do_reset();
    req = 4'b0100;
    cycle();
    chk("t1_granted", 32'(gnt), 32'h4);
    #2 rst = 1'b1;
    #1;
    chk("t1_async_gnt", 32'(gnt), 32'd0);
    chk("t1_async_valid", 32'(gnt_valid), 32'd0);
    chk("t1_async_timeout", 32'(timeout), 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0; req = '0;

    // Watchdog: grant held for exactly MAX_HOLD cycles, then a timeout pulse
    do_reset();
    req = 4'b0001;
    cycle();
    n = 0; nto = 0;
    while (gnt === 4'b0001 && n < 40) begin
      n++;
      if (timeout !== 1'b0) nto++;
      cycle();
    end
    chk("t3_hold_cycles", 32'(n), 32'(MAX_HOLD));
    chk("t3_no_early_timeout", 32'(nto), 32'd0);
    chk("t3_timeout_pulse", 32'(timeout), 32'd1);
    chk("t3_revoked", 32'(gnt), 32'd0);
    cycle();
    chk("t3_timeout_end", 32'(timeout), 32'd0);
    chk("t3_idle_gnt", 32'(gnt), 32'd0);
    cycle();
    chk("t3_regrant", 32'(gnt), 32'h1);

    // done in the final hold cycle wins over watchdog expiry
    do_reset();
    req = 4'b0001;
    cycle();
    repeat (MAX_HOLD - 1) cycle();
    chk("t4_last_hold", 32'(gnt), 32'h1);
    done = 1'b1;
    cycle();
    done = 1'b0;
    chk("t4_released", 32'(gnt), 32'd0);
    chk("t4_no_timeout", 32'(timeout), 32'd0);
    cycle();
    chk("t4_no_timeout_after", 32'(timeout), 32'd0);

    // Grant order with all requesters active and done after every grant
    exp_seq = RR ? '{0, 1, 2, 3, 0} : '{3, 3, 3, 3, 3};
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      found = 1'b0;
      for (int w = 0; w < 10 && !found; w++) begin
        if (gnt_valid === 1'b1) found = 1'b1;
        else cycle();
      end
      chk($sformatf("t6_wait%0d", k), 32'(found), 32'd1);
      chk($sformatf("t6_id%0d", k), 32'(gnt_id), 32'(exp_seq[k]));
      done = 1'b1;
      cycle();
      done = 1'b0;
    end

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) req = 4'($urandom_range(0, 15));
      done = ($urandom_range(0, 9) == 0);
      cycle();
      eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
      chk("rnd_gnt", 32'(gnt), 32'(eg));
      chk("rnd_valid", 32'(gnt_valid), 32'(m_owner >= 0));
      chk("rnd_timeout", 32'(timeout), 32'(m_to));
      if (m_owner >= 0) chk("rnd_gnt_id", 32'(gnt_id), 32'(m_owner));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
